start_stop_counter_gen: RTL and testbench

- Parametrised successor of the board-level start/stop counter.
- Debounces the start_stop and button inputs, then runs a counter that steps on a prescaled tick while running.
- While stopped, button gives a single manual step; while running, button captures a lap value.
- Direction comes from switch; the counter wraps at a configurable modulus; out drives the display/LED path.

---
 rtl/start_stop_counter_gen.sv | 146 ++++++++++++++
 tb/tb_start_stop_counter_gen.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/start_stop_counter_gen.sv
// Start/stop counter: debounced controls, prescaled run stepping, manual step, lap capture.
// Counts up or down within 0..MAX_COUNT and flags every wrap-around with a one-cycle pulse.
module start_stop_counter_gen #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned MAX_COUNT       = 2**WIDTH - 1,
    parameter int unsigned TICK_DIV        = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_stop,
    input  logic             button,
    input  logic             switch,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] lap,
    output logic             running,
    output logic             wrap
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0]    TickLast = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0]    DebLast  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] MaxCnt   = WIDTH'(MAX_COUNT);

    typedef enum logic {StStop, StRun} state_e;

    // Bit 0: start_stop, bit 1: button, bit 2: switch.
    logic [2:0]    sync1_q, sync2_q;
    logic [1:0]    deb_q, deb_d, deb_prev_q;
    logic [DW-1:0] cnt_q [2];
    logic [DW-1:0] cnt_d [2];

    state_e           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] lap_q, lap_d;
    logic             wrap_q, wrap_d;

    logic ss_p, btn_p, dir_up, tick, step_en;

    assign ss_p   = deb_q[0] & ~deb_prev_q[0];
    assign btn_p  = deb_q[1] & ~deb_prev_q[1];
    assign dir_up = sync2_q[2];
    assign tick   = (state_q == StRun) && (presc_q == TickLast);

    // Counter only advances while the synced sample disagrees; level flips on the Nth disagreement.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DebLast) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // All decisions use the pre-transition state, so simultaneous events combine.
    always_comb begin
        state_d = state_q;
        presc_d = '0;
        lap_d   = lap_q;
        step_en = 1'b0;
        unique case (state_q)
            StStop: begin
                step_en = btn_p;
                if (ss_p) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                step_en = tick;
                if (btn_p) begin
                    lap_d = out_q;
                end
                if (ss_p) begin
                    state_d = StStop;
                end else if (!tick) begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: state_d = StStop;
        endcase
    end

    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        if (step_en) begin
            if (dir_up) begin
                // >= also recovers from an out-of-range value.
                if (out_q >= MaxCnt) begin
                    out_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    out_d = out_q + 1'b1;
                end
            end else begin
                if (out_q == '0) begin
                    out_d  = MaxCnt;
                    wrap_d = 1'b1;
                end else begin
                    out_d = out_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            state_q    <= StStop;
            presc_q    <= '0;
            out_q      <= '0;
            lap_q      <= '0;
            wrap_q     <= 1'b0;
        end else begin
            sync1_q    <= {switch, button, start_stop};
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            state_q    <= state_d;
            presc_q    <= presc_d;
            out_q      <= out_d;
            lap_q      <= lap_d;
            wrap_q     <= wrap_d;
        end
    end

    assign out     = out_q;
    assign lap     = lap_q;
    assign running = (state_q == StRun);
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_start_stop_counter_gen.sv
// Bench for start_stop_counter_gen (MAX_COUNT=9, TICK_DIV=10, DEBOUNCE_CYCLES=4).
// Rows hold inputs for n edges, then compare against the row's expected outputs.
module tb_start_stop_counter_gen;

    logic       clk;
    logic       rst, start_stop, button, switch;
    logic [3:0] out, lap;
    logic       running, wrap;

    start_stop_counter_gen #(
        .WIDTH          (4),
        .MAX_COUNT      (9),
        .TICK_DIV       (10),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_stop(start_stop),
        .button    (button),
        .switch    (switch),
        .out       (out),
        .lap       (lap),
        .running   (running),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst, ss, btn, sw;
        int         n;
        logic [3:0] out, lap;
        logic       run, wrap;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic void add(string nm, logic r, logic s, logic b, logic w, int n,
                                int o, int l, logic ru, logic wr);
        vec_t v;
        v.name = nm; v.rst = r; v.ss = s; v.btn = b; v.sw = w; v.n = n;
        v.out = 4'(o); v.lap = 4'(l); v.run = ru; v.wrap = wr;
        vecs.push_back(v);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_vec(input vec_t e);
        n_vec++;
        if (out !== e.out || lap !== e.lap || running !== e.run || wrap !== e.wrap) begin
            n_miss++;
            $display("FAIL %s: got out=%0d lap=%0d running=%0b wrap=%0b, want out=%0d lap=%0d running=%0b wrap=%0b",
                     e.name, out, lap, running, wrap, e.out, e.lap, e.run, e.wrap);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    initial begin
        int edges;
        //  name               rst ss btn sw  n   out lap run wrap
        add("rst_1",            1, 0, 0, 0,  1,  0,  0, 0, 0);
        add("rst_10",           1, 0, 0, 0,  9,  0,  0, 0, 0);
        add("release",          0, 0, 0, 0,  1,  0,  0, 0, 0);
        add("glitch_hi",        0, 1, 0, 0,  2,  0,  0, 0, 0);
        add("glitch_ignored",   0, 0, 0, 0, 10,  0,  0, 0, 0);
        add("ss_edge6",         0, 1, 0, 1,  6,  0,  0, 0, 0);
        add("ss_edge7",         0, 1, 0, 1,  1,  0,  0, 1, 0);
        add("pre_first_step",   0, 0, 0, 1,  9,  0,  0, 1, 0);
        add("first_step",       0, 0, 0, 1,  1,  1,  0, 1, 0);
        for (int i = 2; i <= 9; i++) add($sformatf("walk_%0d", i), 0, 0, 0, 1, 10, i, 0, 1, 0);
        add("wrap_9_to_0",      0, 0, 0, 1, 10,  0,  0, 1, 1);
        add("wrap_cleared",     0, 0, 0, 1,  1,  0,  0, 1, 0);
        add("run_to_4",         0, 0, 0, 1, 47,  4,  0, 1, 0);
        add("lap_capture",      0, 0, 1, 1,  7,  5,  5, 1, 0);
        add("count_continues",  0, 0, 0, 1,  5,  6,  5, 1, 0);
        add("pre_ss_tick",      0, 0, 0, 1,  3,  6,  5, 1, 0);
        add("ss_with_tick",     0, 1, 0, 1,  7,  7,  5, 0, 0);
        add("holds_stopped",    0, 0, 0, 1, 20,  7,  5, 0, 0);
        add("restart",          0, 1, 0, 1,  7,  7,  5, 1, 0);
        add("run_at_7",         0, 0, 0, 1,  5,  7,  5, 1, 0);
        add("rst_midrun",       1, 0, 0, 0,  1,  0,  0, 0, 0);
        add("no_steps_after",   0, 0, 0, 0, 30,  0,  0, 0, 0);
        add("manual_down_wrap", 0, 0, 1, 0,  7,  9,  0, 0, 1);
        add("wrap_one_cycle",   0, 0, 0, 0,  1,  9,  0, 0, 0);
        add("btn_release",      0, 0, 0, 0, 10,  9,  0, 0, 0);
        add("manual_down",      0, 0, 1, 0,  7,  8,  0, 0, 0);
        add("btn_release2",     0, 0, 0, 0, 10,  8,  0, 0, 0);
        add("step_and_run",     0, 1, 1, 0,  7,  7,  0, 1, 0);
        add("run_down_step",    0, 0, 0, 0, 10,  6,  0, 1, 0);
        add("lap_and_stop",     0, 1, 1, 0,  7,  6,  6, 0, 0);
        add("stopped_hold",     0, 0, 0, 0, 15,  6,  6, 0, 0);

        rst = 1'b1; start_stop = 1'b0; button = 1'b0; switch = 1'b0;
        foreach (vecs[i]) begin
            rst = vecs[i].rst; start_stop = vecs[i].ss;
            button = vecs[i].btn; switch = vecs[i].sw;
            exp_q.push_back(vecs[i]);
            step(vecs[i].n);
            check_vec(exp_q.pop_front());
        end

        // Three synced cycles high is one short of the debounce threshold.
        start_stop = 1'b1;
        step(3);
        start_stop = 1'b0;
        step(10);
        check_int("glitch3_ignored", int'(running), 0);

        // Bounded wait for the run to start; latency must be exactly 7 edges.
        start_stop = 1'b1;
        edges = 0;
        while (running !== 1'b1 && edges < 20) begin
            step(1);
            edges++;
        end
        check_int("ss_latency_edges", edges, 7);
        start_stop = 1'b0;
        check_int("lap_kept_on_restart", int'(lap), 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
